menu_config_controller: RTL and testbench
=========================================

Name: menu_config_controller

Overview:
Sequencing FSM for the game's pre-play configuration menu. Walks the player through mode, BPM, key (tom) and song selection using the arrow and enter buttons. Drives menu_sel, the per-menu cursor shown on the Arduino display, and the one-cycle registra_* strobes that load the datapath configuration registers. Raises config_pronta so the main game FSM can start.

Parameters:
MODO, 4, number of game modes (options in mode menu, 2..16)
BPM, 2, number of tempo options (2..16)
TOM, 4, number of key options (2..16)
MUSICA, 16, number of songs (2..16)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
iniciar  in  1  level; enters the menu from idle or restarts it from PRONTO
right_arrow_pressed  in  1  active-high level, already debounced
left_arrow_pressed  in  1  active-high level, already debounced
enter_pressed  in  1  active-high level, already debounced
menu_sel  out  3  current menu: 0 idle, 1 modo, 2 bpm, 3 tom, 4 musica, 5 pronto
arduino_out  out  4  cursor index of the current menu (0 outside menus)
registra_modo, registra_bpm, registra_tom, registra_musicas  out  1 each  one-cycle load strobes
modo_sel  out  MODO  one-hot selected mode
bpm_sel  out  BPM  one-hot selected tempo
tom_sel  out  TOM  one-hot selected key
musica_sel  out  MUSICA  one-hot selected song
config_pronta  out  1  high while in PRONTO
db_estado  out  4  state code for debug display

Behaviour:
- Reset (async): state OCIOSO; menu_sel=0; arduino_out=0; all strobes 0; config_pronta=0; each *_sel = one-hot index 0 (bit0=1); stored indices = 0; edge-detect registers = 0.
- Button edges: each button level is registered every cycle; press = level high AND previous sample low. A held button produces exactly one press.
- Priority within a cycle: enter > arrows. Right and left pressed in the same cycle with no enter: both ignored.
- States (db_estado code): OCIOSO 0, MENU_MODO 1, REG_MODO 2, MENU_BPM 3, REG_BPM 4, MENU_TOM 5, REG_TOM 6, MENU_MUSICA 7, REG_MUSICA 8, PRONTO 9.
- OCIOSO: iniciar=1 -> MENU_MODO.
- MENU_x: the cursor is loaded with menu x's stored index on entry, so the last choice is remembered.
  - Right press: cursor+1, wrapping N-1 -> 0.
  - Left press: cursor-1, wrapping 0 -> N-1.
  - N is the parameter for menu x. The cursor updates on the clock edge after the press cycle.
  - Enter press -> REG_x. On that same edge the stored index and x_sel are loaded from the cursor.
- REG_x: lasts exactly one cycle. registra_x=1 only in this state (Moore), and x_sel is already valid.
  - REG_MODO -> MENU_BPM.
  - REG_BPM -> MENU_TOM.
  - REG_TOM -> MENU_MUSICA, except when the stored mode index is 0 (free-play mode), which skips the song menu -> PRONTO. musica_sel is unchanged in that case.
  - REG_MUSICA -> PRONTO.
- PRONTO: config_pronta=1 and menu_sel=5.
  - iniciar press (rising edge) -> MENU_MODO with the stored indices kept.
  - Arrows and enter are ignored.
- menu_sel and arduino_out are registered, follow the state and cursor, and show no glitch in REG states: menu_sel keeps the menu value and arduino_out keeps the cursor.
- Exactly one registra_* is high at any time, or none.
- Button presses arriving during a REG cycle are discarded. Edge registers still update, so no press is replayed later.
- Reset asserted mid-menu: immediate return to reset values. Stored selections are lost.
- Cursor is 4 bits wide. Parameters above 16 are illegal.

Test Plan:
- Reset then iniciar=1 for 1 cycle -> menu_sel=1, arduino_out=0, modo_sel=4'b0001, config_pronta=0.
- In MENU_MODO: 3 right presses then 1 left press (each held 5 cycles) -> arduino_out sequence 1,2,3,2. Left from 0 -> 3. Right from 3 -> 0.
- Enter at cursor 2 in MENU_MODO -> registra_modo high for exactly 1 cycle, modo_sel=4'b0100, next menu_sel=2, arduino_out=0. Right+left in the same cycle -> cursor unchanged.
- Full pass with modo=2, bpm=1, tom=3, musica=15 -> registra_* pulse once each, in order. Final state: bpm_sel=2'b10, tom_sel=4'b1000, musica_sel=16'h8000, config_pronta=1, menu_sel=5.
- Mode 0 selected -> after registra_tom go straight to PRONTO. No registra_musicas; musica_sel keeps its previous value.
- PRONTO then iniciar -> MENU_MODO with cursor = previous mode index. Reset asserted while in MENU_TOM -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/menu_config_controller.sv
// -----------------------------------------------------------------------------
// menu_config_controller
// Sequencing FSM for the pre-play configuration menu. It walks the player
// through the mode, BPM, key (tom) and song menus using the arrow and enter
// buttons, remembers the last choice of each menu, and raises one-cycle load
// strobes for the datapath configuration registers.
//
// State table (code = db_estado_o)
//   OCIOSO      | 0 | idle, waiting for iniciar level
//   MENU_MODO   | 1 | browsing game modes
//   REG_MODO    | 2 | one-cycle load of the selected mode
//   MENU_BPM    | 3 | browsing tempo options
//   REG_BPM     | 4 | one-cycle load of the selected tempo
//   MENU_TOM    | 5 | browsing key options
//   REG_TOM     | 6 | one-cycle load of the key; mode 0 skips the song menu
//   MENU_MUSICA | 7 | browsing songs
//   REG_MUSICA  | 8 | one-cycle load of the selected song
//   PRONTO      | 9 | configuration done; iniciar edge restarts the menu
//
// Ports
//   clock_i, reset_i          system clock, async active-high reset
//   iniciar_i                 enter menu (level in OCIOSO, edge in PRONTO)
//   right/left/enter_*_i      debounced button levels
//   menu_sel_o                current menu (0 idle .. 5 pronto)
//   arduino_out_o             cursor of the current menu (0 outside menus)
//   registra_*_o              one-cycle load strobes
//   *_sel_o                   one-hot stored selections
//   config_pronta_o           high while in PRONTO
//   db_estado_o               state code for debug display
// -----------------------------------------------------------------------------
module menu_config_controller #(
    parameter int MODO   = 4,
    parameter int BPM    = 2,
    parameter int TOM    = 4,
    parameter int MUSICA = 16
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              iniciar_i,
    input  logic              right_arrow_pressed_i,
    input  logic              left_arrow_pressed_i,
    input  logic              enter_pressed_i,
    output logic [2:0]        menu_sel_o,
    output logic [3:0]        arduino_out_o,
    output logic              registra_modo_o,
    output logic              registra_bpm_o,
    output logic              registra_tom_o,
    output logic              registra_musicas_o,
    output logic [MODO-1:0]   modo_sel_o,
    output logic [BPM-1:0]    bpm_sel_o,
    output logic [TOM-1:0]    tom_sel_o,
    output logic [MUSICA-1:0] musica_sel_o,
    output logic              config_pronta_o,
    output logic [3:0]        db_estado_o
);

    typedef enum logic [3:0] {
        OCIOSO      = 4'd0,
        MENU_MODO   = 4'd1,
        REG_MODO    = 4'd2,
        MENU_BPM    = 4'd3,
        REG_BPM     = 4'd4,
        MENU_TOM    = 4'd5,
        REG_TOM     = 4'd6,
        MENU_MUSICA = 4'd7,
        REG_MUSICA  = 4'd8,
        PRONTO      = 4'd9
    } state_t;

    localparam logic [3:0] LAST_MODO   = 4'(MODO - 1);
    localparam logic [3:0] LAST_BPM    = 4'(BPM - 1);
    localparam logic [3:0] LAST_TOM    = 4'(TOM - 1);
    localparam logic [3:0] LAST_MUSICA = 4'(MUSICA - 1);

    localparam logic [MODO-1:0]   ONE_MODO   = {{(MODO-1){1'b0}}, 1'b1};
    localparam logic [BPM-1:0]    ONE_BPM    = {{(BPM-1){1'b0}}, 1'b1};
    localparam logic [TOM-1:0]    ONE_TOM    = {{(TOM-1){1'b0}}, 1'b1};
    localparam logic [MUSICA-1:0] ONE_MUSICA = {{(MUSICA-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [3:0]          cursor_q, cursor_d;
    logic [3:0]          idx_modo_q, idx_modo_d;
    logic [3:0]          idx_bpm_q, idx_bpm_d;
    logic [3:0]          idx_tom_q, idx_tom_d;
    logic [3:0]          idx_musica_q, idx_musica_d;
    logic [MODO-1:0]     modo_sel_q, modo_sel_d;
    logic [BPM-1:0]      bpm_sel_q, bpm_sel_d;
    logic [TOM-1:0]      tom_sel_q, tom_sel_d;
    logic [MUSICA-1:0]   musica_sel_q, musica_sel_d;
    logic [2:0]          menu_sel_q, menu_sel_d;
    logic [3:0]          arduino_q, arduino_d;
    logic                reg_modo_q, reg_modo_d;
    logic                reg_bpm_q, reg_bpm_d;
    logic                reg_tom_q, reg_tom_d;
    logic                reg_musica_q, reg_musica_d;
    logic                pronta_q, pronta_d;
    logic                right_q, left_q, enter_q, iniciar_q;

    logic right_press, left_press, enter_press, iniciar_press;
    logic step_up, step_dn;

    assign right_press   = right_arrow_pressed_i & ~right_q;
    assign left_press    = left_arrow_pressed_i & ~left_q;
    assign enter_press   = enter_pressed_i & ~enter_q;
    assign iniciar_press = iniciar_i & ~iniciar_q;

    // Simultaneous right+left cancel each other; enter is checked first.
    assign step_up = right_press & ~left_press;
    assign step_dn = left_press & ~right_press;

    function automatic logic [3:0] step_cursor(input logic [3:0] v,
                                               input logic [3:0] last,
                                               input logic       up,
                                               input logic       dn);
        if (up)
            return (v == last) ? 4'd0 : v + 4'd1;
        else if (dn)
            return (v == 4'd0) ? last : v - 4'd1;
        else
            return v;
    endfunction

    always_comb begin
        state_d      = state_q;
        cursor_d     = cursor_q;
        idx_modo_d   = idx_modo_q;
        idx_bpm_d    = idx_bpm_q;
        idx_tom_d    = idx_tom_q;
        idx_musica_d = idx_musica_q;
        modo_sel_d   = modo_sel_q;
        bpm_sel_d    = bpm_sel_q;
        tom_sel_d    = tom_sel_q;
        musica_sel_d = musica_sel_q;

        case (state_q)
            OCIOSO: begin
                if (iniciar_i) begin
                    state_d  = MENU_MODO;
                    cursor_d = idx_modo_q;
                end
            end
            MENU_MODO: begin
                if (enter_press) begin
                    state_d    = REG_MODO;
                    idx_modo_d = cursor_q;
                    modo_sel_d = ONE_MODO << cursor_q;
                end else begin
                    cursor_d = step_cursor(cursor_q, LAST_MODO, step_up, step_dn);
                end
            end
            REG_MODO: begin
                state_d  = MENU_BPM;
                cursor_d = idx_bpm_q;
            end
            MENU_BPM: begin
                if (enter_press) begin
                    state_d   = REG_BPM;
                    idx_bpm_d = cursor_q;
                    bpm_sel_d = ONE_BPM << cursor_q;
                end else begin
                    cursor_d = step_cursor(cursor_q, LAST_BPM, step_up, step_dn);
                end
            end
            REG_BPM: begin
                state_d  = MENU_TOM;
                cursor_d = idx_tom_q;
            end
            MENU_TOM: begin
                if (enter_press) begin
                    state_d   = REG_TOM;
                    idx_tom_d = cursor_q;
                    tom_sel_d = ONE_TOM << cursor_q;
                end else begin
                    cursor_d = step_cursor(cursor_q, LAST_TOM, step_up, step_dn);
                end
            end
            REG_TOM: begin
                // Free-play mode (index 0) has no song to pick.
                if (idx_modo_q == 4'd0) begin
                    state_d = PRONTO;
                end else begin
                    state_d  = MENU_MUSICA;
                    cursor_d = idx_musica_q;
                end
            end
            MENU_MUSICA: begin
                if (enter_press) begin
                    state_d      = REG_MUSICA;
                    idx_musica_d = cursor_q;
                    musica_sel_d = ONE_MUSICA << cursor_q;
                end else begin
                    cursor_d = step_cursor(cursor_q, LAST_MUSICA, step_up, step_dn);
                end
            end
            REG_MUSICA: begin
                state_d = PRONTO;
            end
            PRONTO: begin
                if (iniciar_press) begin
                    state_d  = MENU_MODO;
                    cursor_d = idx_modo_q;
                end
            end
            default: begin
                state_d  = OCIOSO;
                cursor_d = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register on the same
    // edge as the state; REG states keep their menu number and cursor.
    always_comb begin
        menu_sel_d   = 3'd0;
        arduino_d    = cursor_d;
        reg_modo_d   = (state_d == REG_MODO);
        reg_bpm_d    = (state_d == REG_BPM);
        reg_tom_d    = (state_d == REG_TOM);
        reg_musica_d = (state_d == REG_MUSICA);
        pronta_d     = (state_d == PRONTO);
        case (state_d)
            MENU_MODO, REG_MODO:     menu_sel_d = 3'd1;
            MENU_BPM, REG_BPM:       menu_sel_d = 3'd2;
            MENU_TOM, REG_TOM:       menu_sel_d = 3'd3;
            MENU_MUSICA, REG_MUSICA: menu_sel_d = 3'd4;
            PRONTO: begin
                menu_sel_d = 3'd5;
                arduino_d  = 4'd0;
            end
            default: begin
                menu_sel_d = 3'd0;
                arduino_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= OCIOSO;
            cursor_q     <= 4'd0;
            idx_modo_q   <= 4'd0;
            idx_bpm_q    <= 4'd0;
            idx_tom_q    <= 4'd0;
            idx_musica_q <= 4'd0;
            modo_sel_q   <= ONE_MODO;
            bpm_sel_q    <= ONE_BPM;
            tom_sel_q    <= ONE_TOM;
            musica_sel_q <= ONE_MUSICA;
            menu_sel_q   <= 3'd0;
            arduino_q    <= 4'd0;
            reg_modo_q   <= 1'b0;
            reg_bpm_q    <= 1'b0;
            reg_tom_q    <= 1'b0;
            reg_musica_q <= 1'b0;
            pronta_q     <= 1'b0;
            right_q      <= 1'b0;
            left_q       <= 1'b0;
            enter_q      <= 1'b0;
            iniciar_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            idx_modo_q   <= idx_modo_d;
            idx_bpm_q    <= idx_bpm_d;
            idx_tom_q    <= idx_tom_d;
            idx_musica_q <= idx_musica_d;
            modo_sel_q   <= modo_sel_d;
            bpm_sel_q    <= bpm_sel_d;
            tom_sel_q    <= tom_sel_d;
            musica_sel_q <= musica_sel_d;
            menu_sel_q   <= menu_sel_d;
            arduino_q    <= arduino_d;
            reg_modo_q   <= reg_modo_d;
            reg_bpm_q    <= reg_bpm_d;
            reg_tom_q    <= reg_tom_d;
            reg_musica_q <= reg_musica_d;
            pronta_q     <= pronta_d;
            // Sampled in every state so presses seen during REG are not replayed.
            right_q      <= right_arrow_pressed_i;
            left_q       <= left_arrow_pressed_i;
            enter_q      <= enter_pressed_i;
            iniciar_q    <= iniciar_i;
        end
    end

    assign menu_sel_o         = menu_sel_q;
    assign arduino_out_o      = arduino_q;
    assign registra_modo_o    = reg_modo_q;
    assign registra_bpm_o     = reg_bpm_q;
    assign registra_tom_o     = reg_tom_q;
    assign registra_musicas_o = reg_musica_q;
    assign modo_sel_o         = modo_sel_q;
    assign bpm_sel_o          = bpm_sel_q;
    assign tom_sel_o          = tom_sel_q;
    assign musica_sel_o       = musica_sel_q;
    assign config_pronta_o    = pronta_q;
    assign db_estado_o        = state_q;

endmodule

// File: tb/tb_menu_config_controller.sv
// -----------------------------------------------------------------------------
// Bench for menu_config_controller. The reference model works per button
// transaction: which menu is shown, the cursor, and the remembered index of
// each menu, updated with modular arithmetic.
// -----------------------------------------------------------------------------
module tb_menu_config_controller;

    localparam int MODO   = 4;
    localparam int BPM    = 2;
    localparam int TOM    = 4;
    localparam int MUSICA = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic iniciar = 1'b0;
    logic right = 1'b0;
    logic left = 1'b0;
    logic enter = 1'b0;

    logic [2:0]        menu_sel;
    logic [3:0]        arduino_out;
    logic              registra_modo, registra_bpm, registra_tom, registra_musicas;
    logic [MODO-1:0]   modo_sel;
    logic [BPM-1:0]    bpm_sel;
    logic [TOM-1:0]    tom_sel;
    logic [MUSICA-1:0] musica_sel;
    logic              config_pronta;
    logic [3:0]        db_estado;

    menu_config_controller #(
        .MODO(MODO), .BPM(BPM), .TOM(TOM), .MUSICA(MUSICA)
    ) dut (
        .clock_i               (clk),
        .reset_i               (rst),
        .iniciar_i             (iniciar),
        .right_arrow_pressed_i (right),
        .left_arrow_pressed_i  (left),
        .enter_pressed_i       (enter),
        .menu_sel_o            (menu_sel),
        .arduino_out_o         (arduino_out),
        .registra_modo_o       (registra_modo),
        .registra_bpm_o        (registra_bpm),
        .registra_tom_o        (registra_tom),
        .registra_musicas_o    (registra_musicas),
        .modo_sel_o            (modo_sel),
        .bpm_sel_o             (bpm_sel),
        .tom_sel_o             (tom_sel),
        .musica_sel_o          (musica_sel),
        .config_pronta_o       (config_pronta),
        .db_estado_o           (db_estado)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Model: m_menu 0 idle, 1..4 menus, 5 pronto; m_reg = menu being stored.
    int nopt [1:4];
    int m_idx[1:4];
    int m_menu, m_cursor, m_reg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic int exp_state();
        if (m_reg != 0) return 2 * m_reg;
        if (m_menu == 0) return 0;
        if (m_menu == 5) return 9;
        return 2 * m_menu - 1;
    endfunction

    task automatic check_all(input string tag);
        int ard;
        int strb;
        ard  = (m_menu >= 1 && m_menu <= 4) ? m_cursor : 0;
        strb = (m_reg == 0) ? 0 : (8 >> (m_reg - 1));
        check($sformatf("%s.menu_sel", tag), 32'(menu_sel), m_menu);
        check($sformatf("%s.arduino", tag), 32'(arduino_out), ard);
        check($sformatf("%s.db_estado", tag), 32'(db_estado), exp_state());
        check($sformatf("%s.strobes", tag),
              32'({registra_modo, registra_bpm, registra_tom, registra_musicas}), strb);
        check($sformatf("%s.pronta", tag), 32'(config_pronta), (m_menu == 5) ? 1 : 0);
        check($sformatf("%s.modo_sel", tag), 32'(modo_sel), 32'(1) << m_idx[1]);
        check($sformatf("%s.bpm_sel", tag), 32'(bpm_sel), 32'(1) << m_idx[2]);
        check($sformatf("%s.tom_sel", tag), 32'(tom_sel), 32'(1) << m_idx[3]);
        check($sformatf("%s.musica_sel", tag), 32'(musica_sel), 32'(1) << m_idx[4]);
    endtask

    task automatic model_reset();
        m_menu = 0; m_cursor = 0; m_reg = 0;
        for (int i = 1; i <= 4; i++) m_idx[i] = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arrow(input int dir, input int hold);
        if (dir > 0) right = 1'b1; else left = 1'b1;
        cyc();
        if (m_menu >= 1 && m_menu <= 4)
            m_cursor = (m_cursor + dir + nopt[m_menu]) % nopt[m_menu];
        check_all("arrow");
        for (int i = 1; i < hold; i++) begin
            cyc();
            check_all("arrow_hold");
        end
        right = 1'b0; left = 1'b0;
        cyc();
        check_all("arrow_rel");
    endtask

    task automatic do_both();
        right = 1'b1; left = 1'b1;
        cyc();
        check_all("both_arrows");
        right = 1'b0; left = 1'b0;
        cyc();
        check_all("both_rel");
    endtask

    // Enter is held three cycles; optionally a right press lands in the REG cycle.
    task automatic do_enter(input bit poke);
        int nxt;
        enter = 1'b1;
        cyc();
        if (m_menu >= 1 && m_menu <= 4) begin
            m_idx[m_menu] = m_cursor;
            m_reg = m_menu;
        end
        check_all("enter_reg");
        if (poke) right = 1'b1;
        cyc();
        if (m_reg != 0) begin
            if (m_menu == 3 && m_idx[1] == 0) nxt = 5;
            else nxt = m_menu + 1;
            m_reg = 0;
            m_menu = nxt;
            m_cursor = (nxt <= 4) ? m_idx[nxt] : 0;
        end
        check_all("after_reg");
        cyc();
        check_all("no_replay");
        enter = 1'b0; right = 1'b0;
        cyc();
        check_all("enter_rel");
    endtask

    task automatic do_iniciar(input int hold);
        iniciar = 1'b1;
        cyc();
        if (m_menu == 0 || m_menu == 5) begin
            m_menu = 1;
            m_cursor = m_idx[1];
        end
        check_all("iniciar");
        for (int i = 1; i < hold; i++) begin
            cyc();
            check_all("iniciar_hold");
        end
        iniciar = 1'b0;
        cyc();
        check_all("iniciar_rel");
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        right = 1'b0; left = 1'b0; enter = 1'b0; iniciar = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        cyc();
        check_all("reset_held");
        rst = 1'b0;
        cyc();
        check_all("reset_rel");
    endtask

    initial begin
        int r;
        nopt[1] = MODO; nopt[2] = BPM; nopt[3] = TOM; nopt[4] = MUSICA;
        model_reset();

        cyc(); cyc();
        check_all("reset");
        rst = 1'b0;
        cyc();
        check_all("post_reset");

        do_iniciar(1);
        do_arrow(1, 5); do_arrow(1, 5); do_arrow(1, 5); do_arrow(-1, 5);
        do_arrow(-1, 2); do_arrow(-1, 2); do_arrow(-1, 2);
        do_arrow(1, 2); do_arrow(1, 2); do_arrow(1, 2);
        do_both();
        do_enter(1'b0);
        do_arrow(1, 3);
        do_enter(1'b1);
        do_arrow(1, 1); do_arrow(1, 1); do_arrow(1, 1);
        do_enter(1'b0);
        do_arrow(-1, 2);
        do_enter(1'b0);
        check("full_pass.musica_sel", 32'(musica_sel), 32'h8000);
        check("full_pass.pronta", 32'(config_pronta), 1);

        do_arrow(1, 2); do_arrow(-1, 2); do_both(); do_enter(1'b0);

        do_iniciar(3);
        do_arrow(-1, 2); do_arrow(-1, 2);
        do_enter(1'b0); do_enter(1'b0); do_enter(1'b0);
        check("free_play.menu_sel", 32'(menu_sel), 5);

        do_iniciar(1);
        do_enter(1'b0); do_enter(1'b0);
        do_arrow(1, 1);
        do_reset();

        for (int t = 0; t < 400; t++) begin
            r = $urandom_range(0, 99);
            if (r < 30)      do_arrow(1, $urandom_range(1, 5));
            else if (r < 55) do_arrow(-1, $urandom_range(1, 5));
            else if (r < 62) do_both();
            else if (r < 85) do_enter(1'($urandom_range(0, 1)));
            else if (r < 97) do_iniciar($urandom_range(1, 3));
            else             do_reset();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
